// File: rtl/trigger_pkg.sv
// Shared encodings for the multi-stage trigger sequencer: FSM states,
// configuration register selectors and per-stage match modes.
package trigger_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_FIRED = 2'd3;

    localparam logic [2:0] CFG_MASK       = 3'd0;
    localparam logic [2:0] CFG_VALUE      = 3'd1;
    localparam logic [2:0] CFG_OCC        = 3'd2;
    localparam logic [2:0] CFG_MODE       = 3'd3;
    localparam logic [2:0] CFG_POST_DELAY = 3'd4;
    localparam logic [2:0] CFG_N_ACTIVE   = 3'd5;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/trigger_sequencer_if.sv
// Configuration write bus of the trigger sequencer; the host side drives
// it through the master modport, the sequencer listens on the slave modport.
interface trigger_sequencer_if #(
    parameter int DATA_W = 33
);
    logic              cfg_we;
    logic [2:0]        cfg_stage;
    logic [2:0]        cfg_sel;
    logic [DATA_W-1:0] cfg_wdata;

    modport master (
        output cfg_we,
        output cfg_stage,
        output cfg_sel,
        output cfg_wdata
    );

    modport slave (
        input cfg_we,
        input cfg_stage,
        input cfg_sel,
        input cfg_wdata
    );
endinterface

// File: rtl/trigger_stage_match.sv
// Mask/value comparator for the stage currently selected by the sequencer,
// with a registered previous-hit flag so edge-mode stages see only 0->1 transitions.
module trigger_stage_match
    import trigger_pkg::*;
#(
    parameter int DATA_W = 33
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] value,
    input  logic              mode,
    input  logic              load_prev,
    output logic              qualify
);
    logic hit;
    logic prev_hit_reg;

    assign hit = ((data ^ value) & mask) == '0;

    // Forcing prev high on stage entry keeps a level already present at entry from counting as an edge.
    always_ff @(posedge clock) begin
        if (reset || load_prev) begin
            prev_hit_reg <= 1'b1;
        end else begin
            prev_hit_reg <= hit;
        end
    end

    assign qualify = hit && ((mode == MODE_LEVEL) || !prev_hit_reg);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger: walks up to STAGES ordered match conditions, applies a
// post-trigger delay, then pulses trig and reports the sample index of the final match.
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int DATA_W = 33,
    parameter int STAGES = 4,
    parameter int CNT_W  = 17
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  data,
    trigger_sequencer_if.slave cfg,
    output logic               trig,
    output logic [CNT_W-1:0]   trig_pos,
    output logic               armed,
    output logic               done,
    output logic [2:0]         stage_idx
);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       STAGES_4 = 4'(STAGES);

    // Arrays span the full 3-bit stage index; entries at or above STAGES keep their defaults.
    logic [DATA_W-1:0] mask_arr  [8];
    logic [DATA_W-1:0] value_arr [8];
    logic [CNT_W-1:0]  occ_arr   [8];
    logic              mode_arr  [8];
    logic [CNT_W-1:0]  post_delay_reg;
    logic [3:0]        n_active_reg;

    logic [1:0]        state_reg;
    logic [2:0]        stage_reg;
    logic [CNT_W-1:0]  occ_cnt_reg;
    logic [CNT_W-1:0]  dly_cnt_reg;
    logic [CNT_W-1:0]  sample_cnt_reg;
    logic              trig_reg;
    logic [CNT_W-1:0]  trig_pos_reg;

    logic              cfg_ok;
    logic [2:0]        n_active_raw;
    logic [3:0]        n_active_next;
    logic [CNT_W-1:0]  occ_sel;
    logic [CNT_W-1:0]  occ_target;
    logic              occ_done;
    logic              last_stage;
    logic              qualify;
    logic              stage_adv;
    logic              load_prev;

    assign cfg_ok       = cfg.cfg_we && (state_reg == ST_IDLE);
    assign n_active_raw = cfg.cfg_wdata[2:0];
    assign n_active_next = (n_active_raw == 3'd0)               ? 4'd1 :
                           ({1'b0, n_active_raw} > STAGES_4)    ? STAGES_4 :
                                                                  {1'b0, n_active_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_stage_cfg
            always_ff @(posedge clock) begin
                if (reset) begin
                    mask_arr[gi]  <= '0;
                    value_arr[gi] <= '0;
                    occ_arr[gi]   <= CNT_ONE;
                    mode_arr[gi]  <= MODE_LEVEL;
                end else if (cfg_ok && (gi < STAGES) && (cfg.cfg_stage == 3'(gi))) begin
                    case (cfg.cfg_sel)
                        CFG_MASK:  mask_arr[gi]  <= cfg.cfg_wdata;
                        CFG_VALUE: value_arr[gi] <= cfg.cfg_wdata;
                        CFG_OCC:   occ_arr[gi]   <= cfg.cfg_wdata[CNT_W-1:0];
                        CFG_MODE:  mode_arr[gi]  <= cfg.cfg_wdata[0];
                        default: ;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            post_delay_reg <= '0;
            n_active_reg   <= 4'd1;
        end else if (cfg_ok) begin
            if (cfg.cfg_sel == CFG_POST_DELAY) begin
                post_delay_reg <= cfg.cfg_wdata[CNT_W-1:0];
            end else if (cfg.cfg_sel == CFG_N_ACTIVE) begin
                n_active_reg <= n_active_next;
            end
        end
    end

    assign occ_sel    = occ_arr[stage_reg];
    assign occ_target = (occ_sel == '0) ? CNT_ONE : occ_sel;
    assign occ_done   = (occ_cnt_reg == occ_target - CNT_ONE);
    assign last_stage = ({1'b0, stage_reg} == n_active_reg - 4'd1);
    assign stage_adv  = (state_reg == ST_ARMED) && start && qualify && occ_done && !last_stage;
    assign load_prev  = (state_reg != ST_ARMED) || stage_adv;

    trigger_stage_match #(
        .DATA_W(DATA_W)
    ) u_match (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .mask      (mask_arr[stage_reg]),
        .value     (value_arr[stage_reg]),
        .mode      (mode_arr[stage_reg]),
        .load_prev (load_prev),
        .qualify   (qualify)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            stage_reg      <= '0;
            occ_cnt_reg    <= '0;
            dly_cnt_reg    <= '0;
            sample_cnt_reg <= '0;
            trig_reg       <= 1'b0;
            trig_pos_reg   <= '0;
        end else begin
            trig_reg <= 1'b0;
            if (!start) begin
                state_reg      <= ST_IDLE;
                stage_reg      <= '0;
                occ_cnt_reg    <= '0;
                dly_cnt_reg    <= '0;
                sample_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg      <= ST_ARMED;
                        stage_reg      <= '0;
                        occ_cnt_reg    <= '0;
                        dly_cnt_reg    <= '0;
                        sample_cnt_reg <= '0;
                    end
                    ST_ARMED: begin
                        if (sample_cnt_reg != '1) begin
                            sample_cnt_reg <= sample_cnt_reg + CNT_ONE;
                        end
                        if (qualify) begin
                            if (occ_done) begin
                                occ_cnt_reg <= '0;
                                if (last_stage) begin
                                    trig_pos_reg <= sample_cnt_reg;
                                    if (post_delay_reg == '0) begin
                                        state_reg <= ST_FIRED;
                                        trig_reg  <= 1'b1;
                                    end else begin
                                        state_reg <= ST_DELAY;
                                    end
                                end else begin
                                    stage_reg <= stage_reg + 3'd1;
                                end
                            end else begin
                                occ_cnt_reg <= occ_cnt_reg + CNT_ONE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (dly_cnt_reg == post_delay_reg - CNT_ONE) begin
                            state_reg <= ST_FIRED;
                            trig_reg  <= 1'b1;
                        end else begin
                            dly_cnt_reg <= dly_cnt_reg + CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign trig      = trig_reg;
    assign trig_pos  = trig_pos_reg;
    assign armed     = (state_reg == ST_ARMED) || (state_reg == ST_DELAY);
    assign done      = (state_reg == ST_FIRED);
    assign stage_idx = stage_reg;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed vector table, hand-written
// corner sequences and randomized configurations checked against a sample-walk model.
module tb_trigger_sequencer;
    import trigger_pkg::*;

    localparam int DATA_W = 33;
    localparam int STAGES = 4;
    localparam int CNT_W  = 17;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] data;
    logic              trig;
    logic [CNT_W-1:0]  trig_pos;
    logic              armed;
    logic              done;
    logic [2:0]        stage_idx;

    trigger_sequencer_if #(.DATA_W(DATA_W)) cfg_if();

    trigger_sequencer #(
        .DATA_W(DATA_W),
        .STAGES(STAGES),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data      (data),
        .cfg       (cfg_if),
        .trig      (trig),
        .trig_pos  (trig_pos),
        .armed     (armed),
        .done      (done),
        .stage_idx (stage_idx)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference configuration as the bench believes the DUT holds it.
    logic [DATA_W-1:0] m_mask [STAGES];
    logic [DATA_W-1:0] m_val  [STAGES];
    int                m_occ  [STAGES];
    bit                m_mode [STAGES];
    int                m_pd;
    int                m_nact;
    logic [DATA_W-1:0] smp [64];

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  value;
        int          occ;
        bit          mode;
        int          pd;
        logic [63:0] samples;
        int          exp_obs;
        int          exp_pos;
    } vec_t;

    vec_t vec [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < STAGES; k++) begin
            m_mask[k] = '0;
            m_val[k]  = '0;
            m_occ[k]  = 1;
            m_mode[k] = 1'b0;
        end
        m_pd   = 0;
        m_nact = 1;
    endtask

    task automatic cfg_write(input int stg, input logic [2:0] sel, input logic [DATA_W-1:0] wd, input bit upd);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_stage = 3'(stg);
        cfg_if.cfg_sel   = sel;
        cfg_if.cfg_wdata = wd;
        tick();
        cfg_if.cfg_we = 1'b0;
        if (upd) begin
            if (sel == CFG_POST_DELAY) begin
                m_pd = int'(wd[CNT_W-1:0]);
            end else if (sel == CFG_N_ACTIVE) begin
                m_nact = int'(wd[2:0]);
            end else if (stg < STAGES) begin
                case (sel)
                    CFG_MASK:  m_mask[stg] = wd;
                    CFG_VALUE: m_val[stg]  = wd;
                    CFG_OCC:   m_occ[stg]  = int'(wd[CNT_W-1:0]);
                    CFG_MODE:  m_mode[stg] = wd[0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cfg_stage(input int stg, input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] value,
                             input int occ, input bit mode);
        cfg_write(stg, CFG_MASK, mask, 1'b1);
        cfg_write(stg, CFG_VALUE, value, 1'b1);
        cfg_write(stg, CFG_OCC, DATA_W'(occ), 1'b1);
        cfg_write(stg, CFG_MODE, DATA_W'(mode), 1'b1);
    endtask

    // Walks the sample list stage by stage; returns the index of the sample that completes the last stage.
    function automatic int model_fire(input int len);
        int k;
        int cnt;
        int need;
        int nact;
        bit prev;
        bit hit;
        bit q;
        k    = 0;
        cnt  = 0;
        prev = 1'b1;
        nact = (m_nact == 0) ? 1 : ((m_nact > STAGES) ? STAGES : m_nact);
        for (int i = 0; i < len; i++) begin
            hit  = (((smp[i] ^ m_val[k]) & m_mask[k]) == '0);
            q    = hit && (!m_mode[k] || !prev);
            prev = hit;
            if (q) begin
                cnt++;
                need = (m_occ[k] == 0) ? 1 : m_occ[k];
                if (cnt >= need) begin
                    if (k == nact - 1) return i;
                    k++;
                    cnt  = 0;
                    prev = 1'b1;
                end
            end
        end
        return -1;
    endfunction

    // Arms, feeds smp[0..len-1] and checks every cycle; exp_obs is the loop index at which trig is seen.
    task automatic run_window(input int len, input int exp_obs, input int exp_pos, input string nm);
        bit fired;
        start = 1'b1;
        data  = '0;
        tick();
        for (int i = 0; i < len; i++) begin
            data = smp[i];
            tick();
            fired = (exp_obs >= 0) && (i >= exp_obs);
            check($sformatf("%s_trig@%0d", nm, i), longint'(trig), longint'(i == exp_obs));
            check($sformatf("%s_done@%0d", nm, i), longint'(done), longint'(fired));
            check($sformatf("%s_armed@%0d", nm, i), longint'(armed), longint'(!fired));
        end
        if (exp_pos >= 0) check($sformatf("%s_trig_pos", nm), longint'(trig_pos), longint'(exp_pos));
        start = 1'b0;
        tick();
        check($sformatf("%s_abort_armed", nm), longint'(armed), 0);
        check($sformatf("%s_abort_done", nm), longint'(done), 0);
        check($sformatf("%s_abort_stage", nm), longint'(stage_idx), 0);
        if (exp_pos >= 0) check($sformatf("%s_pos_held", nm), longint'(trig_pos), longint'(exp_pos));
    endtask

    initial begin
        int f;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_stage = '0;
        cfg_if.cfg_sel   = '0;
        cfg_if.cfg_wdata = '0;

        // Reset held two cycles with start high: everything quiet.
        reset = 1'b1;
        start = 1'b1;
        data  = '1;
        tick();
        tick();
        check("rst_trig", longint'(trig), 0);
        check("rst_trig_pos", longint'(trig_pos), 0);
        check("rst_armed", longint'(armed), 0);
        check("rst_done", longint'(done), 0);
        check("rst_stage_idx", longint'(stage_idx), 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        model_reset();

        // Default config: mask 0 hits on the first armed sample.
        for (int i = 0; i < 64; i++) smp[i] = '0;
        run_window(6, 0, 0, "defaults");

        vec[0] = '{8'h04, 8'h04, 1, 1'b0, 0, 64'h00000000_00040000, 2, 2};
        vec[1] = '{8'h01, 8'h01, 1, 1'b1, 0, 64'h00000000_01000101, 3, 3};
        vec[2] = '{8'hFF, 8'h0A, 3, 1'b0, 0, 64'h00000000_0A0A000A, 3, 3};
        vec[3] = '{8'h0F, 8'h05, 0, 1'b0, 0, 64'h00000000_00000501, 1, 1};
        vec[4] = '{8'h00, 8'h3C, 1, 1'b0, 0, 64'h00000000_00000000, 0, 0};
        vec[5] = '{8'hFF, 8'h07, 1, 1'b0, 2, 64'h00000000_00000700, 3, 1};
        vec[6] = '{8'hFF, 8'h09, 1, 1'b0, 0, 64'h00000000_00000000, -1, -1};
        vec[7] = '{8'h01, 8'h01, 2, 1'b1, 0, 64'h00000001_00010100, 4, 4};

        for (int j = 0; j < 8; j++) begin
            logic [63:0] s;
            cfg_stage(0, DATA_W'(vec[j].mask), DATA_W'(vec[j].value), vec[j].occ, vec[j].mode);
            cfg_write(0, CFG_POST_DELAY, DATA_W'(vec[j].pd), 1'b1);
            cfg_write(0, CFG_N_ACTIVE, DATA_W'(1), 1'b1);
            s = vec[j].samples;
            for (int i = 0; i < 16; i++) smp[i] = (i < 8) ? DATA_W'(s[8*i +: 8]) : '0;
            run_window(16, vec[j].exp_obs, vec[j].exp_pos, $sformatf("vec%0d", j));
        end

        // Two stages: 0A x3 completes stage 0, 55 completes stage 1.
        cfg_stage(0, DATA_W'(8'hFF), DATA_W'(8'h0A), 3, 1'b0);
        cfg_stage(1, DATA_W'(8'hFF), DATA_W'(8'h55), 1, 1'b0);
        cfg_write(0, CFG_POST_DELAY, '0, 1'b1);
        cfg_write(0, CFG_N_ACTIVE, DATA_W'(2), 1'b1);
        start = 1'b1;
        data  = '0;
        tick();
        data = DATA_W'(8'h0A);
        tick();
        check("two_stage_idx0", longint'(stage_idx), 0);
        tick();
        tick();
        check("two_stage_idx1", longint'(stage_idx), 1);
        check("two_stage_no_trig", longint'(trig), 0);
        data = DATA_W'(8'h55);
        tick();
        check("two_stage_trig", longint'(trig), 1);
        check("two_stage_pos", longint'(trig_pos), 3);
        check("two_stage_done", longint'(done), 1);
        start = 1'b0;
        tick();

        // Post delay of 5 after a hit at sample 10.
        cfg_stage(0, DATA_W'(8'hFF), DATA_W'(8'h3C), 1, 1'b0);
        cfg_write(0, CFG_POST_DELAY, DATA_W'(5), 1'b1);
        cfg_write(0, CFG_N_ACTIVE, DATA_W'(1), 1'b1);
        for (int i = 0; i < 64; i++) smp[i] = '0;
        smp[10] = DATA_W'(8'h3C);
        run_window(24, 15, 10, "post_delay");

        // Abort mid-ARMED, then config writes while ARMED must be dropped.
        cfg_stage(0, DATA_W'(8'hFF), DATA_W'(8'h77), 1, 1'b0);
        cfg_write(0, CFG_POST_DELAY, '0, 1'b1);
        start = 1'b1;
        data  = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_armed@%0d", i), longint'(armed), 1);
        end
        start = 1'b0;
        tick();
        check("abort_idle_armed", longint'(armed), 0);
        check("abort_idle_trig", longint'(trig), 0);
        check("abort_pos_held", longint'(trig_pos), 10);
        start = 1'b1;
        tick();
        data = DATA_W'(1);
        cfg_write(0, CFG_VALUE, '0, 1'b0);
        cfg_write(0, CFG_MASK, '0, 1'b0);
        cfg_write(0, CFG_N_ACTIVE, DATA_W'(3), 1'b0);
        data = '0;
        tick();
        tick();
        check("locked_no_trig", longint'(trig), 0);
        check("locked_no_done", longint'(done), 0);
        start = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) smp[i] = '0;
        smp[4] = DATA_W'(8'h77);
        run_window(10, 4, 4, "locked_cfg");

        // Randomized configurations against the model.
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < STAGES; k++) begin
                cfg_stage(k, DATA_W'($urandom_range(0, 7)), DATA_W'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            cfg_write(4 + int'($urandom_range(0, 3)), CFG_MASK, DATA_W'(7), 1'b1);
            cfg_write(0, CFG_POST_DELAY, DATA_W'($urandom_range(0, 4)), 1'b1);
            cfg_write(0, CFG_N_ACTIVE, DATA_W'($urandom_range(0, 7)), 1'b1);
            for (int i = 0; i < 48; i++) smp[i] = DATA_W'($urandom_range(0, 7));
            f = model_fire(48);
            run_window(48, (f < 0) ? -1 : f + m_pd, f, $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
